// File: rtl/dwc_hdmi_rx_ceavid_ctrl.sv
// Sequencing controller for the CEA video regeneration path (align, gen, fifo).
// Latency: all outputs registered; state and outputs update one ihdmiclk after the causing input.
// Backpressure: none; the FIFO full flag is treated as an error event, not as flow control.
//
// Optional build macro: CEAVID_CTRL_WDOG_EN adds a SKIP/ALIGN watchdog that forces RECOVER.
//
// Ports:
//   ihdmiclk, ihdmirst_n         clock / async active-low reset
//   ihdmien, ivid_devalid        enable and upstream valid; either low forces IDLE
//   icfg_ceavid_rst              soft-reset pulse: restart from RESET, clear error count
//   icfg_auto_realign,
//   icfg_realign_th              auto recovery when per-frame errors reach threshold (0 = never)
//   icfg_ignframe                vsync falls skipped before requesting alignment
//   ivid_vsync, ialign_sts,
//   ififo_full                   upstream vsync, align status, FIFO full flag
//   oceavid_rst, oalign_req,
//   ofifo_flush                  controls to align/gen/fifo
//   olock, ostate, oerr_cnt,
//   ostatus_p                    status to the register bank

module dwc_hdmi_rx_ceavid_ctrl #(
  parameter int unsigned RST_HOLD = 8,
  parameter int unsigned ERRCNT_W = 8,
  parameter int unsigned WDOG_W   = 20
) (
  input  logic                ihdmiclk,
  input  logic                ihdmirst_n,
  input  logic                ihdmien,
  input  logic                icfg_ceavid_rst,
  input  logic                icfg_auto_realign,
  input  logic [3:0]          icfg_realign_th,
  input  logic [3:0]          icfg_ignframe,
  input  logic                ivid_devalid,
  input  logic                ivid_vsync,
  input  logic                ialign_sts,
  input  logic                ififo_full,
  output logic                oceavid_rst,
  output logic                oalign_req,
  output logic                ofifo_flush,
  output logic                olock,
  output logic [2:0]          ostate,
  output logic [ERRCNT_W-1:0] oerr_cnt,
  output logic                ostatus_p
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_SKIP    = 3'd2,
    ST_ALIGN   = 3'd3,
    ST_RUN     = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  if (RST_HOLD < 1 || ERRCNT_W < 1 || WDOG_W < 1) begin : g_param_check
    $error("dwc_hdmi_rx_ceavid_ctrl: RST_HOLD, ERRCNT_W and WDOG_W must all be >= 1");
  end

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [3:0]          skip_cnt, skip_nxt;
  logic [4:0]          skip_sum;
  logic [3:0]          frame_err, ferr_nxt;
  logic [ERRCNT_W-1:0] errcnt_nxt;
  logic                vsync_d, align_d, full_d, olock_d;
  logic                vsync_fall, err_ev;

`ifdef CEAVID_CTRL_WDOG_EN
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
`endif

  assign vsync_fall = vsync_d & ~ivid_vsync;
  // Error events are edges: a FIFO that stays full or alignment that stays lost counts once.
  assign err_ev     = (ififo_full & ~full_d) | (align_d & ~ialign_sts);
  assign ostate     = state;

  // Counters default to zero and are only carried while their owning state persists,
  // so every state change clears them without extra bookkeeping.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = '0;
    skip_nxt   = '0;
    ferr_nxt   = '0;
    errcnt_nxt = oerr_cnt;
    skip_sum   = {1'b0, skip_cnt} + {4'd0, vsync_fall};
`ifdef CEAVID_CTRL_WDOG_EN
    wdog_nxt   = '0;
`endif

    if (!ihdmien || !ivid_devalid) begin
      state_nxt = ST_IDLE;
    end else if (icfg_ceavid_rst && state != ST_IDLE) begin
      state_nxt  = ST_RESET;
      errcnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RESET;
        ST_RESET: begin
          if (hold_cnt == HOLD_LAST) state_nxt = ST_SKIP;
          else                       hold_nxt  = hold_cnt + HOLD_W'(1);
        end
        ST_SKIP: begin
          // Live compare: a lowered icfg_ignframe takes effect on the next cycle.
          if (skip_sum >= {1'b0, icfg_ignframe}) state_nxt = ST_ALIGN;
          else                                   skip_nxt  = skip_sum[3:0];
        end
        ST_ALIGN: begin
          if (ialign_sts) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // A vsync fall starts a new frame; an event in that same cycle belongs to it.
          if (vsync_fall)                      ferr_nxt = {3'd0, err_ev};
          else if (err_ev && frame_err != 4'hF) ferr_nxt = frame_err + 4'd1;
          else                                 ferr_nxt = frame_err;
          if (err_ev && oerr_cnt != {ERRCNT_W{1'b1}}) errcnt_nxt = oerr_cnt + ERRCNT_W'(1);
          if (icfg_auto_realign && icfg_realign_th != 4'd0 && ferr_nxt >= icfg_realign_th)
            state_nxt = ST_RECOVER;
        end
        ST_RECOVER: state_nxt = ST_RESET;
        default:    state_nxt = ST_IDLE;
      endcase

`ifdef CEAVID_CTRL_WDOG_EN
      // Watchdog runs only while SKIP/ALIGN is waiting; terminal count counts as one error.
      if ((state == ST_SKIP || state == ST_ALIGN) && state_nxt == state) begin
        wdog_nxt = wdog + WDOG_W'(1);
        if (&wdog_nxt) begin
          state_nxt = ST_RECOVER;
          wdog_nxt  = '0;
          if (oerr_cnt != {ERRCNT_W{1'b1}}) errcnt_nxt = oerr_cnt + ERRCNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
    if (!ihdmirst_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      skip_cnt    <= '0;
      frame_err   <= '0;
      oerr_cnt    <= '0;
      vsync_d     <= 1'b0;
      align_d     <= 1'b0;
      full_d      <= 1'b0;
      olock_d     <= 1'b0;
      oceavid_rst <= 1'b1;
      oalign_req  <= 1'b0;
      ofifo_flush <= 1'b0;
      olock       <= 1'b0;
      ostatus_p   <= 1'b0;
`ifdef CEAVID_CTRL_WDOG_EN
      wdog        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      skip_cnt    <= skip_nxt;
      frame_err   <= ferr_nxt;
      oerr_cnt    <= errcnt_nxt;
      vsync_d     <= ivid_vsync;
      align_d     <= ialign_sts;
      full_d      <= ififo_full;
      // Outputs decode the next state so they change together with ostate.
      oceavid_rst <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
      oalign_req  <= (state_nxt == ST_ALIGN);
      ofifo_flush <= (state_nxt == ST_RECOVER);
      olock       <= (state_nxt == ST_RUN);
      // Status pulse lands in the cycle after olock toggles.
      olock_d     <= olock;
      ostatus_p   <= olock ^ olock_d;
`ifdef CEAVID_CTRL_WDOG_EN
      wdog        <= wdog_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dwc_hdmi_rx_ceavid_ctrl.sv
// Directed bench for dwc_hdmi_rx_ceavid_ctrl with an expected-value queue.
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.

module tb_dwc_hdmi_rx_ceavid_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, soft_rst, auto_realign, devalid, vsync, align_sts, fifo_full;
  logic [3:0] realign_th, ignframe;
  logic       ceavid_rst, align_req, fifo_flush, lock, status_p;
  logic [2:0] state;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_SKIP = 3'd2,
                         S_ALIGN = 3'd3, S_RUN = 3'd4, S_RECOVER = 3'd5;

  always #5 clk = ~clk;

  dwc_hdmi_rx_ceavid_ctrl #(.RST_HOLD(8), .ERRCNT_W(8), .WDOG_W(4)) dut (
    .ihdmiclk          (clk),
    .ihdmirst_n        (rst_n),
    .ihdmien           (en),
    .icfg_ceavid_rst   (soft_rst),
    .icfg_auto_realign (auto_realign),
    .icfg_realign_th   (realign_th),
    .icfg_ignframe     (ignframe),
    .ivid_devalid      (devalid),
    .ivid_vsync        (vsync),
    .ialign_sts        (align_sts),
    .ififo_full        (fifo_full),
    .oceavid_rst       (ceavid_rst),
    .oalign_req        (align_req),
    .ofifo_flush       (fifo_flush),
    .olock             (lock),
    .ostate            (state),
    .oerr_cnt          (err_cnt),
    .ostatus_p         (status_p)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0d but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1; step(1);
    vsync = 1'b0; step(1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state !== s; i++) step(1);
    exp(32'(s));
    chk(tag, 32'(state));
  endtask

  // Two vsync falls pass SKIP (ignframe=2), then wait for the requested state.
  task automatic bring_up(input logic [2:0] target, input string tag);
    wait_state(S_SKIP, 20, {tag, "_skip"});
    vsync_pulse();
    vsync_pulse();
    wait_state(target, 5, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; devalid = 1'b1; soft_rst = 1'b0;
    auto_realign = 1'b0; realign_th = 4'd0; ignframe = 4'd2;
    vsync = 1'b0; align_sts = 1'b0; fifo_full = 1'b0;
    step(3);

    // Reset values
    exp(S_IDLE); exp(1); exp(0); exp(0); exp(0); exp(0); exp(0);
    chk("rst_state", 32'(state));
    chk("rst_ceavid_rst", 32'(ceavid_rst));
    chk("rst_align_req", 32'(align_req));
    chk("rst_flush", 32'(fifo_flush));
    chk("rst_lock", 32'(lock));
    chk("rst_err_cnt", 32'(err_cnt));
    chk("rst_status_p", 32'(status_p));

    // 1: bring-up, RESET held exactly 8 cycles
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 8; i++) begin
      exp(S_RESET); exp(1);
      chk("t1_hold_state", 32'(state));
      chk("t1_hold_rst", 32'(ceavid_rst));
      step(1);
    end
    exp(S_SKIP); exp(0);
    chk("t1_skip_entry", 32'(state));
    chk("t1_rst_released", 32'(ceavid_rst));
    vsync_pulse();
    exp(S_SKIP);
    chk("t1_after_1st_fall", 32'(state));
    vsync_pulse();
    exp(S_ALIGN); exp(1);
    chk("t1_align_entry", 32'(state));
    chk("t1_align_req", 32'(align_req));
    step(1);
    align_sts = 1'b1;
    step(1);
    exp(S_RUN); exp(1); exp(0); exp(0);
    chk("t1_run_state", 32'(state));
    chk("t1_lock", 32'(lock));
    chk("t1_align_req_drop", 32'(align_req));
    chk("t1_status_not_yet", 32'(status_p));
    step(1);
    exp(1);
    chk("t1_status_pulse", 32'(status_p));
    step(1);
    exp(0);
    chk("t1_status_single", 32'(status_p));

    // 2: two FIFO-full rises in one frame, th=2, auto on -> RECOVER
    auto_realign = 1'b1; realign_th = 4'd2;
    fifo_full = 1'b1; step(1);
    exp(S_RUN); exp(1);
    chk("t2_after_1st_err", 32'(state));
    chk("t2_err_cnt_1", 32'(err_cnt));
    fifo_full = 1'b0; step(1);
    fifo_full = 1'b1; step(1);
    exp(S_RECOVER); exp(1); exp(2); exp(0);
    chk("t2_recover", 32'(state));
    chk("t2_flush", 32'(fifo_flush));
    chk("t2_err_cnt_2", 32'(err_cnt));
    chk("t2_lock_drop", 32'(lock));
    fifo_full = 1'b0; step(1);
    exp(S_RESET); exp(0); exp(1);
    chk("t2_reset_after", 32'(state));
    chk("t2_flush_one_cycle", 32'(fifo_flush));
    chk("t2_status_pulse", 32'(status_p));
    bring_up(S_RUN, "t2_rerun");

    // 4: soft reset mid-RUN
    step(3);
    soft_rst = 1'b1; step(1);
    soft_rst = 1'b0;
    exp(S_RESET); exp(0); exp(0); exp(1);
    chk("t4_state", 32'(state));
    chk("t4_err_clear", 32'(err_cnt));
    chk("t4_lock", 32'(lock));
    chk("t4_ceavid_rst", 32'(ceavid_rst));
    step(1);
    exp(1);
    chk("t4_status_pulse", 32'(status_p));
    bring_up(S_RUN, "t4_rerun");

    // 3: one error per frame over four frames stays in RUN
    for (int f = 0; f < 4; f++) begin
      fifo_full = 1'b1; step(1);
      fifo_full = 1'b0; step(1);
      vsync_pulse();
      exp(S_RUN);
      chk("t3_frame_run", 32'(state));
    end
    exp(4);
    chk("t3_err_cnt_4", 32'(err_cnt));
    // Event coinciding with vsync fall counts toward the new frame
    vsync = 1'b1; step(1);
    vsync = 1'b0; fifo_full = 1'b1; step(1);
    exp(S_RUN); exp(5);
    chk("t3_same_cycle_run", 32'(state));
    chk("t3_err_cnt_5", 32'(err_cnt));
    fifo_full = 1'b0; step(1);
    fifo_full = 1'b1; step(1);
    exp(S_RECOVER); exp(6);
    chk("t3_same_cycle_recover", 32'(state));
    chk("t3_err_cnt_6", 32'(err_cnt));
    fifo_full = 1'b0; step(1);

    // 5: devalid drop in RESET; enable low beats soft reset
    step(2);
    exp(S_RESET);
    chk("t5_in_reset", 32'(state));
    devalid = 1'b0; step(1);
    exp(S_IDLE); exp(1);
    chk("t5_devalid_idle", 32'(state));
    chk("t5_idle_rst", 32'(ceavid_rst));
    devalid = 1'b1; step(1);
    exp(S_RESET);
    chk("t5_restart", 32'(state));
    en = 1'b0; soft_rst = 1'b1; step(1);
    exp(S_IDLE);
    chk("t5_en_beats_soft", 32'(state));
    en = 1'b1; soft_rst = 1'b0; step(1);
    soft_rst = 1'b1; step(1);
    soft_rst = 1'b0;
    exp(S_RESET); exp(0);
    chk("t5_soft_in_reset", 32'(state));
    chk("t5_err_cleared", 32'(err_cnt));

    // 6: alignment never arrives
    align_sts = 1'b0;
    bring_up(S_ALIGN, "t6_align");
`ifdef CEAVID_CTRL_WDOG_EN
    step(14);
    exp(S_ALIGN);
    chk("t6_still_align_15", 32'(state));
    step(1);
    exp(S_RECOVER); exp(1);
    chk("t6_wdog_recover", 32'(state));
    chk("t6_wdog_err", 32'(err_cnt));
`else
    step(30);
    exp(S_ALIGN); exp(1); exp(0);
    chk("t6_stays_align", 32'(state));
    chk("t6_align_req", 32'(align_req));
    chk("t6_err_unchanged", 32'(err_cnt));
    align_sts = 1'b1; step(1);
    exp(S_RUN);
    chk("t6_late_lock", 32'(state));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
